// File: rtl/caterr_pkg.sv
// caterr_pkg: state encodings, first-error codes and default timing for the CATERR classifier
package caterr_pkg;
  typedef enum logic [3:0] {
    ST_IDLE      = 4'h1,
    ST_MEASURE   = 4'h2,
    ST_IERR_HOLD = 4'h4,
    ST_WAIT_HIGH = 4'h8
  } stateT;
  localparam logic [1:0] FE_NONE = 2'b00;
  localparam logic [1:0] FE_MCERR = 2'b01;
  localparam logic [1:0] FE_IERR = 2'b10;
  localparam logic [31:0] T_MIN_PULSE_DEF = 32'd4;
  localparam logic [31:0] T_IERR_50M_DEF = 32'd50000;
endpackage

// File: rtl/caterr_evt_cntr.sv
// caterr_evt_cntr: saturating event counter; an increment coincident with clear leaves the count at 1
module caterr_evt_cntr #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 iClk_50M,
  input  logic                 iRst_n,
  input  logic                 iInc,
  input  logic                 iClr,
  output logic [CNT_WIDTH-1:0] oCnt
);
  // count up to all-ones and hold; clear restarts from the coincident increment
  always_ff @(posedge iClk_50M)
    if (!iRst_n) oCnt <= '0;
    else if (iClr) oCnt <= CNT_WIDTH'(iInc);
    else if (iInc && !(&oCnt)) oCnt <= oCnt + CNT_WIDTH'(1);
endmodule

// File: rtl/caterr_classifier.sv
// caterr_classifier: classifies delayed CATERR lows as MCERR/IERR/glitch; CATERR_FIRST_ERR_LOG_EN adds oFirstErr
module caterr_classifier
  import caterr_pkg::*;
#(
  parameter logic [31:0] T_MIN_PULSE = T_MIN_PULSE_DEF,
  parameter logic [31:0] T_IERR_50M = T_IERR_50M_DEF,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 iClk_50M,
  input  logic                 iRst_n,
  input  logic                 iCpuPwrgdDly,
  input  logic                 iCaterr_n,
  input  logic                 iClrStatus,
  output logic                 oMcerr,
  output logic                 oIerr,
  output logic [CNT_WIDTH-1:0] oMcerrCnt,
  output logic [CNT_WIDTH-1:0] oIerrCnt,
  output logic                 oEvt
`ifdef CATERR_FIRST_ERR_LOG_EN
  ,
  output logic [1:0]           oFirstErr
`endif
);
  localparam int WW = $clog2(T_IERR_50M + 32'd1);
  logic ff1, ff2, ff3, fall;
  stateT state, stateNext;
  logic [WW-1:0] rWidth, widthNext;
  logic mcerrHit, ierrHit;

  // two-flop synchroniser plus edge stage, parked high while the CPU is unpowered
  always_ff @(posedge iClk_50M)
    if (!iRst_n || !iCpuPwrgdDly) {ff1, ff2, ff3} <= 3'b111;
    else {ff1, ff2, ff3} <= {iCaterr_n, ff1, ff2};

  assign fall = !ff2 && ff3;

  // state and width registers
  always_ff @(posedge iClk_50M)
    if (!iRst_n) begin
      state <= ST_IDLE;
      rWidth <= '0;
    end else begin
      state <= stateNext;
      rWidth <= widthNext;
    end

  // next state, width and classification; loss of power abandons any partial assertion
  always_comb begin
    stateNext = ST_IDLE;
    widthNext = '0;
    mcerrHit = 1'b0;
    ierrHit = 1'b0;
    if (iCpuPwrgdDly)
      case (state)
        ST_IDLE: begin
          stateNext = fall ? ST_MEASURE : ST_IDLE;
          widthNext = fall ? WW'(1) : '0;
        end
        ST_MEASURE:
          if (!ff2) begin
            ierrHit = rWidth == WW'(T_IERR_50M - 32'd1);
            stateNext = ierrHit ? ST_IERR_HOLD : ST_MEASURE;
            widthNext = rWidth + WW'(1);
          end else mcerrHit = 32'(rWidth) >= T_MIN_PULSE;
        ST_IERR_HOLD: begin
          stateNext = ff2 ? ST_WAIT_HIGH : ST_IERR_HOLD;
          widthNext = ff2 ? '0 : rWidth;
        end
        ST_WAIT_HIGH: stateNext = ST_IDLE;
        default: stateNext = ST_IDLE;
      endcase
  end

  // sticky flags and event strobe; a classification in the clear cycle wins
  always_ff @(posedge iClk_50M)
    if (!iRst_n) begin
      oMcerr <= 1'b0;
      oIerr <= 1'b0;
      oEvt <= 1'b0;
    end else begin
      oMcerr <= mcerrHit || (oMcerr && !iClrStatus);
      oIerr <= ierrHit || (oIerr && !iClrStatus);
      oEvt <= mcerrHit || ierrHit;
    end

  caterr_evt_cntr #(.CNT_WIDTH(CNT_WIDTH)) uMcerrCnt (
    .iClk_50M(iClk_50M),
    .iRst_n(iRst_n),
    .iInc(mcerrHit),
    .iClr(iClrStatus),
    .oCnt(oMcerrCnt)
  );

  caterr_evt_cntr #(.CNT_WIDTH(CNT_WIDTH)) uIerrCnt (
    .iClk_50M(iClk_50M),
    .iRst_n(iRst_n),
    .iInc(ierrHit),
    .iClr(iClrStatus),
    .oCnt(oIerrCnt)
  );

`ifdef CATERR_FIRST_ERR_LOG_EN
  // latch the type of the first event since reset or clear
  always_ff @(posedge iClk_50M)
    if (!iRst_n) oFirstErr <= FE_NONE;
    else if (iClrStatus || oFirstErr == FE_NONE)
      oFirstErr <= ierrHit ? FE_IERR : mcerrHit ? FE_MCERR : FE_NONE;
`endif
endmodule

// File: tb/tb_caterr_classifier.sv
// tb_caterr_classifier: randomized pulse-width stimulus against a width-rule reference model
module tb_caterr_classifier;
  localparam logic [31:0] TMIN = 32'd4;
  localparam logic [31:0] TIERR = 32'd100;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rstN = 1'b0, pwrgd = 1'b0, caterrN = 1'b1, clr = 1'b0;
  logic mcerr, ierr, evt;
  logic [CW-1:0] mcerrCnt, ierrCnt;
`ifdef CATERR_FIRST_ERR_LOG_EN
  logic [1:0] firstErr;
`endif
  int checks = 0, errors = 0;
  bit mMcerr, mIerr;
  int mMcerrCnt, mIerrCnt, mFirst;

  always #10 clk = ~clk;

  caterr_classifier #(.T_MIN_PULSE(TMIN), .T_IERR_50M(TIERR), .CNT_WIDTH(CW)) dut (
    .iClk_50M(clk),
    .iRst_n(rstN),
    .iCpuPwrgdDly(pwrgd),
    .iCaterr_n(caterrN),
    .iClrStatus(clr),
    .oMcerr(mcerr),
    .oIerr(ierr),
    .oMcerrCnt(mcerrCnt),
    .oIerrCnt(ierrCnt),
    .oEvt(evt)
`ifdef CATERR_FIRST_ERR_LOG_EN
    ,
    .oFirstErr(firstErr)
`endif
  );

  // 0 glitch, 1 MCERR, 2 IERR, from the low width alone
  function automatic int clsOf(input int n);
    return (n >= int'(TIERR)) ? 2 : (n >= int'(TMIN)) ? 1 : 0;
  endfunction

  // clock index (counting from the first edge that sees the low) where oEvt is expected
  function automatic int idxOf(input int n);
    return (clsOf(n) == 2) ? int'(TIERR) + 2 : n + 3;
  endfunction

  task automatic modelClear();
    mMcerr = 0; mIerr = 0; mMcerrCnt = 0; mIerrCnt = 0; mFirst = 0;
  endtask

  task automatic modelApply(input int cls);
    if (cls == 1) begin
      mMcerr = 1;
      mMcerrCnt = (mMcerrCnt == CMAX) ? CMAX : mMcerrCnt + 1;
    end
    if (cls == 2) begin
      mIerr = 1;
      mIerrCnt = (mIerrCnt == CMAX) ? CMAX : mIerrCnt + 1;
    end
    if (mFirst == 0) mFirst = cls;
  endtask

  // drive one low of n clocks; optional power drop and clear at given indices; observe oEvt
  task automatic runPulse(input int n, input int dropAt, input int clrAt, output int nEvt, output int idx);
    int last;
    last = ((n > int'(TIERR)) ? n : int'(TIERR)) + 8;
    nEvt = 0;
    idx = -1;
    caterrN = 1'b0;
    for (int i = 1; i <= last; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (evt) begin
        nEvt++;
        idx = i;
      end
      if (i == n) caterrN = 1'b1;
      if (dropAt > 0 && i >= dropAt) pwrgd = 1'b0;
      clr = (i == clrAt);
    end
    caterrN = 1'b1;
    clr = 1'b0;
    pwrgd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic doClear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    modelClear();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    pwrgd = 1'b1;
    repeat (3) @(negedge clk);
    modelClear();
    checks++;
    if ({mcerr, ierr, evt, mcerrCnt, ierrCnt} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %b expected 0", {mcerr, ierr, evt, mcerrCnt, ierrCnt});
    end
`ifdef CATERR_FIRST_ERR_LOG_EN
    checks++;
    if (firstErr !== 2'b00) begin errors++; $display("FAIL reset firstErr: got %b expected 00", firstErr); end
`endif
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_glitch();
    int nEvt, idx;
    runPulse(3, -1, -1, nEvt, idx);
    checks++;
    if (nEvt != 0 || {mcerr, ierr, mcerrCnt, ierrCnt} !== '0) begin
      errors++;
      $display("FAIL glitch3: got evt=%0d status=%b expected 0/0", nEvt, {mcerr, ierr, mcerrCnt, ierrCnt});
    end
    runPulse(4, -1, -1, nEvt, idx);
    modelApply(1);
    checks++;
    if (nEvt != 1 || idx != 7) begin errors++; $display("FAIL min4 evt: got cnt=%0d idx=%0d expected 1/7", nEvt, idx); end
    checks++;
    if (mcerr !== 1'b1 || mcerrCnt !== CW'(1) || ierr !== 1'b0) begin
      errors++;
      $display("FAIL min4 status: got mcerr=%b cnt=%0d ierr=%b expected 1/1/0", mcerr, mcerrCnt, ierr);
    end
  endtask

  task automatic test_mcerr();
    int nEvt, idx;
    runPulse(8, -1, -1, nEvt, idx);
    modelApply(1);
    checks++;
    if (nEvt != 1 || idx != 11) begin errors++; $display("FAIL mcerr8 evt: got cnt=%0d idx=%0d expected 1/11", nEvt, idx); end
    checks++;
    if (mcerrCnt !== CW'(mMcerrCnt) || ierr !== 1'b0) begin
      errors++;
      $display("FAIL mcerr8 status: got cnt=%0d ierr=%b expected %0d/0", mcerrCnt, ierr, mMcerrCnt);
    end
  endtask

  task automatic test_ierr();
    int nEvt, idx;
    doClear();
    runPulse(500, -1, -1, nEvt, idx);
    modelApply(2);
    checks++;
    if (nEvt != 1 || idx != int'(TIERR) + 2) begin
      errors++;
      $display("FAIL ierr500 evt: got cnt=%0d idx=%0d expected 1/%0d", nEvt, idx, TIERR + 2);
    end
    checks++;
    if (ierr !== 1'b1 || ierrCnt !== CW'(1) || mcerrCnt !== CW'(0) || mcerr !== 1'b0) begin
      errors++;
      $display("FAIL ierr500 status: got ierr=%b icnt=%0d mcnt=%0d mcerr=%b expected 1/1/0/0", ierr, ierrCnt, mcerrCnt, mcerr);
    end
    runPulse(8, -1, -1, nEvt, idx);
    modelApply(1);
    checks++;
    if (nEvt != 1 || mcerrCnt !== CW'(1) || mcerr !== 1'b1) begin
      errors++;
      $display("FAIL post-ierr mcerr: got evt=%0d mcnt=%0d mcerr=%b expected 1/1/1", nEvt, mcerrCnt, mcerr);
    end
`ifdef CATERR_FIRST_ERR_LOG_EN
    checks++;
    if (firstErr !== 2'b10) begin errors++; $display("FAIL firstErr ierr-then-mcerr: got %b expected 10", firstErr); end
    doClear();
    checks++;
    if (firstErr !== 2'b00) begin errors++; $display("FAIL firstErr clear: got %b expected 00", firstErr); end
`endif
  endtask

  task automatic test_random();
    int n, cls, nEvt, idx;
    for (int k = 0; k < 12; k++) begin
      n = (k == 0) ? int'(TIERR) - 1 : (k == 1) ? int'(TIERR) : int'($urandom_range(1, 130));
      cls = clsOf(n);
      runPulse(n, -1, -1, nEvt, idx);
      modelApply(cls);
      checks++;
      if (nEvt != (cls != 0 ? 1 : 0) || (cls != 0 && idx != idxOf(n))) begin
        errors++;
        $display("FAIL rand n=%0d evt: got cnt=%0d idx=%0d expected %0d/%0d", n, nEvt, idx, cls != 0, idxOf(n));
      end
      checks++;
      if (mcerr !== mMcerr || ierr !== mIerr || mcerrCnt !== CW'(mMcerrCnt) || ierrCnt !== CW'(mIerrCnt)) begin
        errors++;
        $display("FAIL rand n=%0d status: got %b %b %0d %0d expected %b %b %0d %0d", n, mcerr, ierr, mcerrCnt, ierrCnt,
                 mMcerr, mIerr, mMcerrCnt, mIerrCnt);
      end
`ifdef CATERR_FIRST_ERR_LOG_EN
      checks++;
      if (firstErr !== 2'(mFirst)) begin errors++; $display("FAIL rand n=%0d firstErr: got %b expected %0d", n, firstErr, mFirst); end
`endif
    end
  endtask

  task automatic test_saturation();
    int n, nEvt, idx;
    doClear();
    checks++;
    if ({mcerr, ierr, mcerrCnt, ierrCnt} !== '0) begin
      errors++;
      $display("FAIL idle clear: got %b expected 0", {mcerr, ierr, mcerrCnt, ierrCnt});
    end
    for (int k = 0; k < 5; k++) begin
      runPulse(int'($urandom_range(4, 99)), -1, -1, nEvt, idx);
      modelApply(1);
    end
    checks++;
    if (mcerrCnt !== CW'(CMAX) || mcerr !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d mcerr=%b expected %0d/1", mcerrCnt, mcerr, CMAX);
    end
    n = int'($urandom_range(4, 99));
    runPulse(n, -1, n + 2, nEvt, idx);
    modelClear();
    modelApply(1);
    checks++;
    if (nEvt != 1 || mcerr !== 1'b1 || mcerrCnt !== CW'(1) || ierrCnt !== CW'(0)) begin
      errors++;
      $display("FAIL clear+event n=%0d: got evt=%0d mcerr=%b mcnt=%0d icnt=%0d expected 1/1/1/0", n, nEvt, mcerr, mcerrCnt, ierrCnt);
    end
`ifdef CATERR_FIRST_ERR_LOG_EN
    checks++;
    if (firstErr !== 2'b01) begin errors++; $display("FAIL clear+event firstErr: got %b expected 01", firstErr); end
`endif
  endtask

  task automatic test_power_loss();
    int nEvt, idx;
    runPulse(150, -1, -1, nEvt, idx);
    modelApply(2);
    runPulse(100, 50, -1, nEvt, idx);
    checks++;
    if (nEvt != 0) begin errors++; $display("FAIL power loss evt: got %0d expected 0", nEvt); end
    checks++;
    if (mcerr !== mMcerr || ierr !== mIerr || mcerrCnt !== CW'(mMcerrCnt) || ierrCnt !== CW'(mIerrCnt)) begin
      errors++;
      $display("FAIL power loss retain: got %b %b %0d %0d expected %b %b %0d %0d", mcerr, ierr, mcerrCnt, ierrCnt,
               mMcerr, mIerr, mMcerrCnt, mIerrCnt);
    end
    runPulse(8, -1, -1, nEvt, idx);
    modelApply(1);
    checks++;
    if (nEvt != 1 || idx != 11 || mcerrCnt !== CW'(mMcerrCnt)) begin
      errors++;
      $display("FAIL rearm after power loss: got evt=%0d idx=%0d cnt=%0d expected 1/11/%0d", nEvt, idx, mcerrCnt, mMcerrCnt);
    end
  endtask

  initial begin
    modelClear();
    @(negedge clk);
    test_reset();
    test_glitch();
    test_mcerr();
    test_ierr();
    test_random();
    test_saturation();
    test_power_loss();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/caterr_classifier.md
Name: caterr_classifier

Overview:
Downstream consumer of the delayed CATERR output (FM_CPU_CATERR_DLY_LVT3_N). Measures each CATERR low assertion and classifies it:
- short pulse: MCERR
- held low beyond a threshold: IERR
- sub-minimum width: glitch, discarded
Keeps sticky status and saturating event counts for the BMC/SMBus register file, which clears them with a pulse.

Parameters:
- T_MIN_PULSE, default 32'd4: minimum low width in clocks to count as an event; shorter is a glitch.
- T_IERR_50M, default 32'd50000: low width in clocks (1 ms at 50 MHz) at which the event is classified IERR.
- CNT_WIDTH, default 8: width of each saturating event counter.

Ports:
- iClk_50M, input, 1: 50 MHz clock.
- iRst_n, input, 1: reset.
- iCpuPwrgdDly, input, 1: delayed CPU power-good; classification enabled only while high.
- iCaterr_n, input, 1: delayed CATERR, active-low, asynchronous to iClk_50M.
- iClrStatus, input, 1: one-cycle clear from the register file.
- oMcerr, output, 1: sticky, an MCERR has been seen.
- oIerr, output, 1: sticky, an IERR has been seen.
- oMcerrCnt, output, CNT_WIDTH: saturating MCERR count.
- oIerrCnt, output, CNT_WIDTH: saturating IERR count.
- oEvt, output, 1: one-cycle pulse on every classified event.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (iClk_50M, iRst_n). Reset sets all outputs to 0, state to ST_IDLE, width counter to 0, sync flops to 1.
- Input sync:
  - Two-flop synchroniser on iCaterr_n (ff1, ff2), plus ff3 for edge detect.
  - Falling edge = !ff2 && ff3.
  - The sync flops are forced to 1 while iCpuPwrgdDly = 0.
- State machine, one-hot: ST_IDLE, ST_MEASURE, ST_IERR_HOLD, ST_WAIT_HIGH.
  - ST_IDLE: on falling edge, go to ST_MEASURE and load rWidth = 1.
  - ST_MEASURE, ff2 = 0: rWidth increments. When rWidth == T_IERR_50M-1 on an increment, do all of the following in the same cycle:
    - set oIerr
    - increment oIerrCnt
    - pulse oEvt
    - go to ST_IERR_HOLD
  - ST_MEASURE, ff2 = 1: the captured width is rWidth.
    - If rWidth >= T_MIN_PULSE: set oMcerr, increment oMcerrCnt, pulse oEvt.
    - Otherwise: no report.
    - Go to ST_IDLE in either case.
  - ST_IERR_HOLD: wait for ff2 = 1, then go to ST_WAIT_HIGH.
  - ST_WAIT_HIGH: one-cycle re-arm; go to ST_IDLE. A falling edge detected in this cycle is ignored.
  - Illegal encoding: go to ST_IDLE.
- Width rules:
  - rWidth is $clog2(T_IERR_50M+1) bits and never exceeds T_IERR_50M.
  - An input low for exactly N clocks (N < T_IERR_50M) yields captured width N.
- Latency:
  - oEvt for MCERR is 3 clocks after iCaterr_n rises.
  - oEvt for IERR is T_IERR_50M+2 clocks after iCaterr_n falls.
- Counters saturate at all-ones; further events still set sticky bits and pulse oEvt.
- iClrStatus clears oMcerr, oIerr and both counters.
  - A set or increment in the same cycle wins: the bit ends at 1 and the counter ends at 1.
- iCpuPwrgdDly low mid-operation:
  - State returns to ST_IDLE and rWidth goes to 0; no event is reported for the partial assertion.
  - Sticky bits and counters are retained for post-mortem BMC read.
- One event in progress at a time. A new falling edge while in ST_MEASURE is impossible without an intervening rise.

Optional Feature:
CATERR_FIRST_ERR_LOG_EN
- Defined:
  - Adds output oFirstErr [1:0]: 00 none, 01 MCERR, 10 IERR.
  - Latched on the first classified event after reset or clear; later events do not change it.
  - iClrStatus clears it; a simultaneous event re-latches that event's type.
- Undefined: port absent, no logic.

Decomposition:
- Package caterr_pkg:
  - state encodings ST_IDLE=4'h1, ST_MEASURE=4'h2, ST_IERR_HOLD=4'h4, ST_WAIT_HIGH=4'h8
  - first-error codes
  - default timing constants (T_MIN_PULSE, T_IERR_50M)
- Sub-module caterr_evt_cntr: CNT_WIDTH saturating counter with inc, clr, clr-vs-inc priority rule. Instantiated twice.

Test Plan:
- MCERR: pwrgd=1, iCaterr_n low 8 clocks -> oEvt 3 clocks after rise, oMcerr=1, oMcerrCnt=1, oIerr=0.
- Glitch: low 3 clocks with T_MIN_PULSE=4 -> no oEvt, all status 0. Low exactly 4 clocks -> MCERR.
- IERR: T_IERR_50M=100, hold low 500 clocks -> single oEvt at clock 102 after fall, oIerr=1, oIerrCnt=1, oMcerrCnt=0. Rise, then an 8-clock pulse -> MCERR counted.
- Saturation/clear: CNT_WIDTH=2, 5 MCERR pulses -> oMcerrCnt=3. iClrStatus coincident with a 6th classification -> oMcerr=1, oMcerrCnt=1.
- Power loss: pwrgd drops 50 clocks into a 100-clock low -> no event, state ST_IDLE, prior counts retained. Reset -> all 0.
- CATERR_FIRST_ERR_LOG_EN: IERR then MCERR -> oFirstErr=10. Clear -> 00.
